// File: rtl/jt900h_intc.sv
// jt900h_intc -- prioritised interrupt controller for the jt900h CPU.
//
// Collects NSRC peripheral interrupt lines into pending flags (edge or level
// mode, per source), picks the highest-priority enabled request and presents
// it to the CPU as irq/int_lvl. On irq_ack the serviced source's vector is
// latched on ack_vec. A byte-wide register per source holds level and mode.
//
// Optional build macro: JT900H_NMI_EN adds an edge-triggered nmi input that
// overrides every source at level 7 and acknowledges with vector 8'h04.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cen          clock enable; every register advances only when cen=1
//   src          peripheral interrupt lines
//   addr/din/we  register select, write data, write strobe
//   dout         register read data (combinational from addr)
//   irq/int_lvl  request and its priority level to the CPU
//   irq_ack      one-cycle acknowledge from the CPU
//   ack_vec      vector of the most recently acknowledged source
//   nmi          (JT900H_NMI_EN only) non-maskable interrupt line

// Per-source pending logic: edge history, level/mode register, pending flag.
module jt900h_intc_src (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       src,
    input  logic       wr,       // register write to this source
    input  logic [2:0] wlvl,
    input  logic       wmode,
    input  logic       wkeep,    // din[7]: 1 keeps pending, 0 clears it
    input  logic       ack_clr,  // acknowledge clears this edge-mode pending
    output logic [2:0] lvl,
    output logic       mode,
    output logic       pend
);
    logic src_q;
    logic primed;   // low until the first cen cycle after reset
    logic rise;
    logic eff_mode;

    // The first sample after reset only loads history, so a line that is
    // already high when reset releases is not mistaken for an edge.
    assign rise     = src & ~src_q & primed;
    // A write that changes mode governs the pending update of its own cycle.
    assign eff_mode = wr ? wmode : mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= 1'b0;
            primed <= 1'b0;
            lvl    <= 3'd0;
            mode   <= 1'b0;
            pend   <= 1'b0;
        end else if (cen) begin
            src_q  <= src;
            primed <= 1'b1;
            if (wr) begin
                lvl  <= wlvl;
                mode <= wmode;
            end
            // A new edge always wins over an ack or write clear.
            if (eff_mode) pend <= rise | (pend & ~ack_clr & ~(wr & ~wkeep));
            else          pend <= src;
        end
    end
endmodule

module jt900h_intc #(
    parameter int         NSRC     = 8,
    parameter logic [7:0] VEC_BASE = 8'h20,
    parameter logic [7:0] SPUR_VEC = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [NSRC-1:0] src,
    input  logic [3:0]      addr,
    input  logic [7:0]      din,
    input  logic            we,
    output logic [7:0]      dout,
    output logic            irq,
    output logic [2:0]      int_lvl,
    input  logic            irq_ack,
    output logic [7:0]      ack_vec
`ifdef JT900H_NMI_EN
    ,
    input  logic            nmi
`endif
);
    logic [NSRC-1:0]      wr_sel;
    logic [NSRC-1:0]      ack_clr;
    logic [NSRC-1:0]      mode;
    logic [NSRC-1:0]      pend;
    logic [NSRC-1:0][2:0] lvl;
    logic [3:0]           win;
    logic                 win_nmi;
    logic                 ack_hit;
    logic                 nmi_live;
    logic [2:0]           best_lvl;
    logic [3:0]           best_idx;
    logic                 unused_din;

    assign unused_din = ^din[6:4];   // read-as-zero bits, never stored
    assign ack_hit    = cen & irq_ack & irq;

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            assign wr_sel[g]  = cen & we & (addr == 4'(g));
            assign ack_clr[g] = ack_hit & ~win_nmi & (win == 4'(g)) & mode[g];
            jt900h_intc_src u_src (
                .clk     (clk),
                .rst_n   (rst_n),
                .cen     (cen),
                .src     (src[g]),
                .wr      (wr_sel[g]),
                .wlvl    (din[2:0]),
                .wmode   (din[3]),
                .wkeep   (din[7]),
                .ack_clr (ack_clr[g]),
                .lvl     (lvl[g]),
                .mode    (mode[g]),
                .pend    (pend[g])
            );
        end
    endgenerate

`ifdef JT900H_NMI_EN
    logic nmi_q;
    logic nmi_primed;
    logic nmi_pend;
    logic nmi_clr;

    assign nmi_clr  = ack_hit & win_nmi;
    assign nmi_live = nmi_pend & ~nmi_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_q      <= 1'b0;
            nmi_primed <= 1'b0;
            nmi_pend   <= 1'b0;
        end else if (cen) begin
            nmi_q      <= nmi;
            nmi_primed <= 1'b1;
            nmi_pend   <= (nmi & ~nmi_q & nmi_primed) | nmi_live;
        end
    end
`else
    assign nmi_live = 1'b0;
`endif

    // Highest level wins; strict compare keeps the lowest index on ties.
    // The source being acknowledged this cycle is masked so the CPU never
    // sees a stale request for an edge it has already serviced.
    always_comb begin
        best_lvl = 3'd0;
        best_idx = 4'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && !ack_clr[i] && lvl[i] > best_lvl) begin
                best_lvl = lvl[i];
                best_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq     <= 1'b0;
            int_lvl <= 3'd0;
            win     <= 4'd0;
            win_nmi <= 1'b0;
            ack_vec <= SPUR_VEC;
        end else if (cen) begin
            if (nmi_live) begin
                irq     <= 1'b1;
                int_lvl <= 3'd7;
                win_nmi <= 1'b1;
            end else begin
                irq     <= best_lvl != 3'd0;
                int_lvl <= best_lvl;
                win     <= best_idx;
                win_nmi <= 1'b0;
            end
            if (irq_ack) begin
                if (!irq)         ack_vec <= SPUR_VEC;
                else if (win_nmi) ack_vec <= 8'h04;
                else              ack_vec <= VEC_BASE + {4'd0, win};
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(addr) == i) dout = {pend[i], 3'b000, mode[i], lvl[i]};
        end
    end
endmodule

// File: tb/tb_jt900h_intc.sv
// Self-checking bench for jt900h_intc: expected ack vectors go into a
// scoreboard queue as requests are raised and are popped on each acknowledge.
module tb_jt900h_intc;
    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cen = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic [3:0]      addr = 4'd0;
    logic [7:0]      din = 8'd0;
    logic            we = 1'b0;
    logic [7:0]      dout;
    logic            irq;
    logic [2:0]      int_lvl;
    logic            irq_ack = 1'b0;
    logic [7:0]      ack_vec;
`ifdef JT900H_NMI_EN
    logic            nmi = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];
    logic [7:0] exp;

    jt900h_intc #(.NSRC(NSRC), .VEC_BASE(8'h20), .SPUR_VEC(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .src(src), .addr(addr), .din(din),
        .we(we), .dout(dout), .irq(irq), .int_lvl(int_lvl), .irq_ack(irq_ack),
        .ack_vec(ack_vec)
`ifdef JT900H_NMI_EN
        , .nmi(nmi)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr = a; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0d exp=0", irq); end
        checks++; if (int_lvl !== 3'd0) begin errors++; $display("FAIL reset_lvl got=%0d exp=0", int_lvl); end
        checks++; if (ack_vec !== 8'hFF) begin errors++; $display("FAIL reset_vec got=%h exp=ff", ack_vec); end
        addr = 4'd3; #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        wr(4'd2, 8'h0D);
        src[2] = 1'b1; tick(); src[2] = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_lat1 got=%0d exp=0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || int_lvl !== 3'd5) begin errors++; $display("FAIL basic_irq got=%0d/%0d exp=1/5", irq, int_lvl); end
        sb.push_back(8'h22);
        ack();
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL basic_vec got=%h exp=%h", ack_vec, exp); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_clear got=%0d exp=0", irq); end
    endtask

    task automatic test_priority();
        wr(4'd1, 8'h0B);
        wr(4'd6, 8'h0E);
        src[1] = 1'b1; src[6] = 1'b1; tick(); src = '0; tick();
        checks++; if (int_lvl !== 3'd6) begin errors++; $display("FAIL prio_lvl got=%0d exp=6", int_lvl); end
        sb.push_back(8'h26); sb.push_back(8'h21);
        ack();
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL prio_vec1 got=%h exp=%h", ack_vec, exp); end
        tick();
        checks++; if (irq !== 1'b1 || int_lvl !== 3'd3) begin errors++; $display("FAIL prio_next got=%0d/%0d exp=1/3", irq, int_lvl); end
        ack();
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL prio_vec2 got=%h exp=%h", ack_vec, exp); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_idle got=%0d exp=0", irq); end
    endtask

    task automatic test_tie();
        wr(4'd0, 8'h0C);
        wr(4'd3, 8'h0C);
        src[0] = 1'b1; src[3] = 1'b1; tick(); src = '0; tick();
        checks++; if (int_lvl !== 3'd4) begin errors++; $display("FAIL tie_lvl got=%0d exp=4", int_lvl); end
        sb.push_back(8'h20); sb.push_back(8'h23);
        for (int k = 0; k < 2; k++) begin
            ack();
            exp = sb.pop_front();
            checks++; if (ack_vec !== exp) begin errors++; $display("FAIL tie_vec%0d got=%h exp=%h", k, ack_vec, exp); end
            tick();
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tie_idle got=%0d exp=0", irq); end
    endtask

    task automatic test_level();
        wr(4'd4, 8'h02);
        src[4] = 1'b1; tick(); tick();
        checks++; if (irq !== 1'b1 || int_lvl !== 3'd2) begin errors++; $display("FAIL lvl_irq got=%0d/%0d exp=1/2", irq, int_lvl); end
        sb.push_back(8'h24);
        ack();
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL lvl_vec got=%h exp=%h", ack_vec, exp); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lvl_hold got=%0d exp=1", irq); end
        src[4] = 1'b0; tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lvl_drop1 got=%0d exp=1", irq); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lvl_drop2 got=%0d exp=0", irq); end
        wr(4'd4, 8'h00);
    endtask

    task automatic test_spurious_and_collide();
        sb.push_back(8'hFF);
        ack();
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL spur_vec got=%h exp=%h", ack_vec, exp); end
        wr(4'd5, 8'h0F);
        src[5] = 1'b1; tick(); src[5] = 1'b0; tick();
        // new edge on src5 in the same cycle its pending is acknowledged
        sb.push_back(8'h25);
        src[5] = 1'b1; ack(); src[5] = 1'b0;
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL coll_vec got=%h exp=%h", ack_vec, exp); end
        addr = 4'd5; #1;
        checks++; if (dout !== 8'h8F) begin errors++; $display("FAIL coll_pend got=%h exp=8f", dout); end
        wr(4'd5, 8'h00);
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_idle got=%0d exp=0", irq); end
    endtask

    task automatic test_regs();
        wr(4'd8, 8'h0F);
        addr = 4'd8; #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reg_oor got=%h exp=00", dout); end
        src[6] = 1'b1; tick(); src[6] = 1'b0; tick();
        wr(4'd6, 8'h8E);
        addr = 4'd6; #1;
        checks++; if (dout !== 8'h8E) begin errors++; $display("FAIL reg_keep got=%h exp=8e", dout); end
        src[6] = 1'b1; wr(4'd6, 8'h0E); src[6] = 1'b0;
        #1;
        checks++; if (dout !== 8'h8E) begin errors++; $display("FAIL reg_setwins got=%h exp=8e", dout); end
        wr(4'd6, 8'h0E);
        #1;
        checks++; if (dout !== 8'h0E) begin errors++; $display("FAIL reg_clear got=%h exp=0e", dout); end
        tick(); tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reg_idle got=%0d exp=0", irq); end
    endtask

    task automatic test_cen();
        cen = 1'b0;
        src[1] = 1'b1; tick(); src[1] = 1'b0; tick();
        cen = 1'b1; tick(); tick();
        addr = 4'd1; #1;
        checks++; if (irq !== 1'b0 || dout !== 8'h0B) begin errors++; $display("FAIL cen_pulse got=%0d/%h exp=0/0b", irq, dout); end
        // edge arriving while frozen is seen on the first enabled cycle
        cen = 1'b0;
        src[1] = 1'b1; tick(); tick();
        cen = 1'b1; tick();
        checks++; if (dout !== 8'h8B) begin errors++; $display("FAIL cen_held got=%h exp=8b", dout); end
        src[1] = 1'b0; tick();
        checks++; if (irq !== 1'b1 || int_lvl !== 3'd3) begin errors++; $display("FAIL cen_irq got=%0d/%0d exp=1/3", irq, int_lvl); end
        sb.push_back(8'h21);
        ack();
        exp = sb.pop_front();
        checks++; if (ack_vec !== exp) begin errors++; $display("FAIL cen_vec got=%h exp=%h", ack_vec, exp); end
    endtask

`ifdef JT900H_NMI_EN
    task automatic test_nmi();
        wr(4'd7, 8'h0F);
        src[7] = 1'b1; nmi = 1'b1; tick(); src[7] = 1'b0; nmi = 1'b0; tick();
        checks++; if (irq !== 1'b1 || int_lvl !== 3'd7) begin errors++; $display("FAIL nmi_irq got=%0d/%0d exp=1/7", irq, int_lvl); end
        sb.push_back(8'h04); sb.push_back(8'h27);
        for (int k = 0; k < 2; k++) begin
            ack();
            exp = sb.pop_front();
            checks++; if (ack_vec !== exp) begin errors++; $display("FAIL nmi_vec%0d got=%h exp=%h", k, ack_vec, exp); end
            tick();
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nmi_idle got=%0d exp=0", irq); end
    endtask
`endif

    task automatic test_async_reset();
        src[2] = 1'b1; tick(); src[2] = 1'b0; tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ares_pre got=%0d exp=1", irq); end
        #2 rst_n = 1'b0;
        addr = 4'd2; #1;
        checks++; if (irq !== 1'b0 || int_lvl !== 3'd0 || ack_vec !== 8'hFF || dout !== 8'h00)
            begin errors++; $display("FAIL ares_now got=%0d/%0d/%h/%h exp=0/0/ff/00", irq, int_lvl, ack_vec, dout); end
        // line already high at release must not count as an edge
        src[2] = 1'b1;
        tick();
        rst_n = 1'b1;
        wr(4'd2, 8'h0D);
        tick(); tick();
        #1;
        checks++; if (irq !== 1'b0 || dout !== 8'h0D) begin errors++; $display("FAIL ares_rel got=%0d/%h exp=0/0d", irq, dout); end
        src[2] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_tie();
        test_level();
        test_spurious_and_collide();
        test_regs();
        test_cen();
`ifdef JT900H_NMI_EN
        test_nmi();
`endif
        test_async_reset();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_left got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
